// File: rtl/dm_port_arbiter_if.sv
// Request, response and memory-side signals of the data-memory port arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic [1:0]        req;
  logic [1:0]        wr;
  logic [31:0]       addr0;
  logic [31:0]       addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic [3:0]        be0;
  logic [3:0]        be1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [31:0]       rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req, wr, addr0, addr1, wdata0, wdata1, be0, be1, mem_rdata,
    output gnt, done, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req, wr, addr0, addr1, wdata0, wdata1, be0, be1, mem_rdata,
    input  gnt, done, rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin sharing of the single-ported data memory between the M stage and the bridge.
// done arrives 2 cycles after req for full/empty writes, 3 for reads, 4 for byte-enable writes.
module dm_port_arbiter #(
  parameter int ADDR_W = 12
) (
  input logic              clk,
  input logic              reset,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RDWAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_last_grant;
  logic              r_owner;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_merged;
  logic [31:0]       r_rdata;

  logic              w_any_req;
  logic              w_winner;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_be;
  logic [31:0]       w_merged;
  logic [1:0]        w_owner_oh;
  logic              w_rmw;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [31:0]       w_mem_wdata;
  logic              w_unused;

  assign w_any_req = |bus.req;
  assign w_unused  = ^{bus.addr0[31:ADDR_W+2], bus.addr0[1:0],
                       bus.addr1[31:ADDR_W+2], bus.addr1[1:0]};

  // A lone requester wins outright; under contention the port that did not win last time goes.
  always_comb begin
    w_winner = bus.req[1];
    if (bus.req == 2'b11) begin
      w_winner = ~r_last_grant;
    end
    w_sel_wr    = w_winner ? bus.wr[1] : bus.wr[0];
    w_sel_addr  = w_winner ? bus.addr1[ADDR_W+1:2] : bus.addr0[ADDR_W+1:2];
    w_sel_wdata = w_winner ? bus.wdata1 : bus.wdata0;
    w_sel_be    = w_winner ? bus.be1 : bus.be0;
  end

  always_comb begin
    w_merged = bus.mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) begin
        w_merged[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  assign w_rmw = r_wr && (r_be != 4'b1111) && (r_be != 4'b0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes come from state alone so an asynchronous reset drops them immediately.
  always_comb begin
    w_next      = r_state;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!r_wr || w_rmw) begin
          w_mem_re = 1'b1;
          w_next   = S_RDWAIT;
        end else begin
          if (r_be == 4'b1111) begin
            w_mem_we    = 1'b1;
            w_mem_wdata = r_wdata;
          end
          w_next = S_DONE;
        end
      end
      S_RDWAIT: begin
        w_next = r_wr ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = r_merged;
        w_next      = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_merged     <= '0;
      r_rdata      <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_owner <= w_winner;
        r_wr    <= w_sel_wr;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_be    <= w_sel_be;
        if (bus.req == 2'b11) begin
          r_last_grant <= w_winner;
        end
      end
      if (r_state == S_RDWAIT) begin
        if (r_wr) begin
          r_merged <= w_merged;
        end else begin
          r_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign w_owner_oh    = r_owner ? 2'b10 : 2'b01;
  assign bus.gnt       = (r_state != S_IDLE) ? w_owner_oh : 2'b00;
  assign bus.done      = (r_state == S_DONE) ? w_owner_oh : 2'b00;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rdata     = r_rdata;
  assign bus.mem_addr  = (r_state == S_IDLE) ? '0 : r_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_re    = w_mem_re;

  a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(w_mem_we && w_mem_re));

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench for dm_port_arbiter against a transaction-level model of memory,
// round-robin ownership and per-operation latency.
module tb_dm_port_arbiter;
  localparam int ADDR_W = 12;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  dm_port_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Word memory with one-cycle registered read.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] mem_q;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) mem_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = mem_q;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] ref_rdata;
  logic        ref_lg;

  always @(negedge clk) begin
    if (!reset) begin
      if ((bus.mem_we && bus.mem_re) || bus.gnt == 2'b11 || (bus.done & ~bus.gnt) != 2'b00 ||
          (!bus.busy && (bus.mem_we || bus.mem_re)))
        viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic op_t rand_op(input int max_word);
    op_t o;
    int  k;
    o.wr    = 1'($urandom_range(0, 1));
    o.addr  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, max_word)) << 2);
    o.wdata = $urandom;
    k       = int'($urandom_range(0, 3));
    o.be    = (k == 0) ? 4'hF : (k == 1) ? 4'h0 : 4'($urandom_range(1, 14));
    return o;
  endfunction

  // Reference: latency, strobe cycles and written word follow from the op type alone.
  task automatic model_apply(input op_t o, output int lat, output int re_c, output int we_c,
                             output logic [31:0] wword, output logic [31:0] rd);
    int          w;
    logic [31:0] mask;
    w    = widx(o.addr);
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (o.be[i]) mask = mask | (32'hFF << (8 * i));
    wword = 32'h0;
    if (!o.wr) begin
      lat = 3; re_c = 1; we_c = 0;
      ref_rdata = ref_mem[w];
    end else if (o.be == 4'hF) begin
      lat = 2; re_c = 0; we_c = 1;
      wword = o.wdata;
      ref_mem[w] = wword;
    end else if (o.be == 4'h0) begin
      lat = 2; re_c = 0; we_c = 0;
    end else begin
      lat = 4; re_c = 1; we_c = 3;
      wword = (o.wdata & mask) | (ref_mem[w] & ~mask);
      ref_mem[w] = wword;
    end
    rd = ref_rdata;
  endtask

  task automatic drive_port(input int p, input op_t o);
    bus.wr[p] = o.wr;
    if (p == 0) begin
      bus.addr0 = o.addr; bus.wdata0 = o.wdata; bus.be0 = o.be;
    end else begin
      bus.addr1 = o.addr; bus.wdata1 = o.wdata; bus.be1 = o.be;
    end
  endtask

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic do_op(input int p, input op_t o);
    int          lat, re_c, we_c, c, n_we, n_re, got_we, got_re, bad;
    logic [31:0] ww, rd, we_dat, st_addr;
    bit          seen;
    model_apply(o, lat, re_c, we_c, ww, rd);
    drive_port(p, o);
    bus.req[p] = 1'b1;
    c = 0; n_we = 0; n_re = 0; got_we = 0; got_re = 0; bad = 0; seen = 0;
    we_dat = 32'h0; st_addr = 32'h0;
    if (bus.gnt !== 2'b00) bad++;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (bus.gnt !== onehot(p)) bad++;
      if (bus.mem_we) begin n_we++; got_we = c; we_dat = bus.mem_wdata; st_addr = 32'(bus.mem_addr); end
      if (bus.mem_re) begin n_re++; got_re = c; st_addr = 32'(bus.mem_addr); end
      if (c == 1) drive_port(p, rand_op(4095));
      if (bus.done != 2'b00) begin
        seen = 1;
        chk("op_done_port", 32'(bus.done), 32'(onehot(p)));
        chk("op_latency", c, lat);
        chk("op_rdata", bus.rdata, rd);
        bus.req[p] = 1'b0;
      end
    end
    if (!seen) chk("op_done_timeout", 0, 1);
    chk("op_n_we", n_we, (we_c != 0) ? 1 : 0);
    chk("op_we_cycle", got_we, we_c);
    chk("op_n_re", n_re, (re_c != 0) ? 1 : 0);
    chk("op_re_cycle", got_re, re_c);
    if (we_c != 0) chk("op_we_data", we_dat, ww);
    if (we_c != 0 || re_c != 0) chk("op_mem_addr", st_addr, widx(o.addr));
    chk("op_gnt_cycles", bad, 0);
    @(negedge clk);
    chk("op_idle_busy", 32'(bus.busy), 0);
  endtask

  // Both ports request in the same IDLE cycle; the loser is served right after the winner.
  task automatic do_pair(input op_t o0, input op_t o1);
    int          w, l, lw, ll, rc, wc, c, exp_l;
    logic [31:0] ww, rdw, rdl;
    bit          dw, dl;
    op_t         ow, ol;
    w = ref_lg ? 0 : 1;
    l = 1 - w;
    ref_lg = 1'(w);
    ow = (w == 1) ? o1 : o0;
    ol = (w == 1) ? o0 : o1;
    model_apply(ow, lw, rc, wc, ww, rdw);
    model_apply(ol, ll, rc, wc, ww, rdl);
    exp_l = lw + 1 + ll;
    drive_port(0, o0);
    drive_port(1, o1);
    bus.req = 2'b11;
    c = 0; dw = 0; dl = 0;
    while (!(dw && dl) && c < 40) begin
      @(negedge clk);
      c++;
      if (bus.done[w]) begin
        dw = 1;
        chk("pair_win_lat", c, lw);
        chk("pair_win_rdata", bus.rdata, rdw);
        bus.req[w] = 1'b0;
      end
      if (bus.done[l]) begin
        dl = 1;
        chk("pair_lose_lat", c, exp_l);
        chk("pair_lose_rdata", bus.rdata, rdl);
        bus.req[l] = 1'b0;
      end
    end
    if (!(dw && dl)) chk("pair_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    op_t         o;
    logic [31:0] old;
    int          nd, last_c, c, p, ep;

    reset = 1'b1;
    bus.req = 2'b00; bus.wr = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.be0 = '0; bus.be1 = '0;
    ref_lg = 1'b1;
    ref_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_re", 32'(bus.mem_re), 0);

    // Directed: full write, read back on port 1, byte-lane RMW, empty-enable write.
    o = '{wr: 1'b1, addr: 32'h0000_0010, wdata: 32'h1234_5678, be: 4'b1111};
    do_op(0, o);
    o = '{wr: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, be: 4'b0000};
    do_op(1, o);
    chk("dir_read_val", bus.rdata, 32'h1234_5678);
    o = '{wr: 1'b1, addr: 32'h0000_0010, wdata: 32'h00AB_0000, be: 4'b0100};
    do_op(0, o);
    chk("dir_rmw_mem", mem[4], 32'h12AB_5678);
    o = '{wr: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, be: 4'b0000};
    do_op(0, o);
    chk("dir_be0_mem", mem[4], 32'h12AB_5678);

    for (int w = 0; w < 8; w++) begin
      o = '{wr: 1'b1, addr: 32'(w) << 2, wdata: $urandom, be: 4'hF};
      do_op(w % 2, o);
    end

    // Both ports hold read requests: ownership must alternate every 4 cycles.
    drive_port(0, '{wr: 1'b0, addr: 32'h4, wdata: 32'h0, be: 4'h0});
    drive_port(1, '{wr: 1'b0, addr: 32'h8, wdata: 32'h0, be: 4'h0});
    bus.req = 2'b11;
    nd = 0; last_c = 0; c = 0;
    while (nd < 4 && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.done != 2'b00) begin
        p  = bus.done[1] ? 1 : 0;
        ep = ref_lg ? 0 : 1;
        ref_lg = 1'(ep);
        ref_rdata = ref_mem[ep + 1];
        chk("rr_port", p, ep);
        chk("rr_done_onehot", 32'(bus.done), 32'(onehot(ep)));
        chk("rr_rdata", bus.rdata, ref_rdata);
        if (nd > 0) chk("rr_spacing", c - last_c, 4);
        else        chk("rr_first", c, 3);
        last_c = c;
        nd++;
        if (nd == 4) bus.req = 2'b00;
      end
    end
    if (nd < 4) chk("rr_timeout", nd, 4);
    @(negedge clk);

    for (int i = 0; i < 30; i++) do_op(int'($urandom_range(0, 1)), rand_op(7));
    for (int i = 0; i < 10; i++) do_pair(rand_op(7), rand_op(7));

    // Asynchronous reset while the merged word is being written.
    old = ref_mem[3];
    drive_port(0, '{wr: 1'b1, addr: 32'hC, wdata: ~old, be: 4'b0011});
    bus.req[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pre_we", 32'(bus.mem_we), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_we", 32'(bus.mem_we), 0);
    chk("rst_mid_gnt", 32'(bus.gnt), 0);
    chk("rst_mid_done", 32'(bus.done), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_rdata", bus.rdata, 0);
    bus.req = 2'b00;
    ref_lg = 1'b1;
    ref_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_kept", mem[3], old);
    do_op(1, '{wr: 1'b0, addr: 32'hC, wdata: 32'h0, be: 4'h0});
    do_pair(rand_op(7), rand_op(7));

    for (int w = 0; w < 8; w++) chk("final_mem", mem[w], ref_mem[w]);
    chk("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
